// File: rtl/alu64bit_arbiter.sv
// Round-robin arbiter that shares one combinational alu64bit among NREQ clients; operands registered and held.
// Latency: response valid ALU_LAT edges after accept; backpressure: response held until rsp_ready, no new grant until then.
module alu64bit_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 64,
  parameter int ALU_LAT = 4,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_cin,
  input  logic [NREQ*2-1:0]       req_op,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  output logic                    alu_cin,
  output logic [1:0]              alu_op,
  input  logic [WIDTH-1:0]        alu_s,
  input  logic                    alu_cout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_s,
  output logic                    rsp_cout
);

  localparam int LATW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [1:0]       op;
  } alu_in_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  gnt_id;
  logic [LATW-1:0] lat_cnt;
  alu_in_t         alu_q;
  alu_in_t         pick_in;
  logic            found;
  logic [IDW-1:0]  pick_id;
  logic [IDW-1:0]  next_ptr;

  assign alu_a   = alu_q.a;
  assign alu_b   = alu_q.b;
  assign alu_cin = alu_q.cin;
  assign alu_op  = alu_q.op;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    pick_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        found   = 1'b1;
        pick_id = IDW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    pick_in.a   = req_a[int'(pick_id)*WIDTH +: WIDTH];
    pick_in.b   = req_b[int'(pick_id)*WIDTH +: WIDTH];
    pick_in.cin = req_cin[pick_id];
    pick_in.op  = req_op[int'(pick_id)*2 +: 2];
    next_ptr    = (pick_id == IDW'(NREQ-1)) ? '0 : pick_id + IDW'(1);
  end

  // rst_n gates the grant so nothing is offered while reset is held.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (found && rst_n) begin
          req_ready = NREQ'(1) << pick_id;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (lat_cnt == '0) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      gnt_id    <= '0;
      lat_cnt   <= '0;
      alu_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_s     <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            alu_q   <= pick_in;
            gnt_id  <= pick_id;
            rr_ptr  <= next_ptr;
            lat_cnt <= LATW'(ALU_LAT-1);
          end
        end
        EXEC: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LATW'(1);
          end else begin
            rsp_s     <= alu_s;
            rsp_cout  <= alu_cout;
            rsp_id    <= gnt_id;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu64bit_arbiter.sv
// Directed bench for alu64bit_arbiter with a behavioural adder standing in for alu64bit.
module tb_alu64bit_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [255:0] req_a;
  logic [255:0] req_b;
  logic [3:0]   req_cin;
  logic [7:0]   req_op;
  logic [63:0]  alu_a;
  logic [63:0]  alu_b;
  logic         alu_cin;
  logic [1:0]   alu_op;
  logic [63:0]  alu_s;
  logic         alu_cout;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [63:0]  rsp_s;
  logic         rsp_cout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  alu64bit_arbiter #(.NREQ(4), .WIDTH(64), .ALU_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_s(alu_s), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_cout(rsp_cout)
  );

  assign {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, alu_b} + {64'b0, alu_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed no completion expected summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic [1:0] op);
    req_a[i*64 +: 64] = a;
    req_b[i*64 +: 64] = b;
    req_cin[i]        = cin;
    req_op[i*2 +: 2]  = op;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("rsp_valid_seen", {63'b0, rsp_valid}, 64'd1);
  endtask

  initial begin
    int n;
    int tg;
    int tprev;
    logic seen;
    logic [63:0] exp_s [4];
    exp_s[0] = 64'h105;
    exp_s[1] = 64'h206;
    exp_s[2] = 64'h305;
    exp_s[3] = 64'h406;
    tprev = 0;

    // Reset: grant must stay off even with every request raised.
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_a = '0; req_b = '0; req_cin = '0; req_op = '0;
    req_valid = 4'hF;
    tick(); tick();
    chk("rst_req_ready", {60'b0, req_ready}, 64'h0);
    chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'h0);
    chk("rst_alu_a", alu_a, 64'h0);
    chk("rst_rsp_s", rsp_s, 64'h0);
    chk("rst_rsp_id", {62'b0, rsp_id}, 64'h0);
    req_valid = 4'h0;
    rst_n = 1'b1;
    tick();

    // 1: single request from req0, overflow into cout.
    set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 2'b10);
    req_valid = 4'b0001;
    #1;
    chk("t1_grant", {60'b0, req_ready}, 64'h1);
    tick();
    req_valid = 4'b0000;
    chk("t1_ready_drop", {60'b0, req_ready}, 64'h0);
    chk("t1_alu_a", alu_a, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t1_alu_op", {62'b0, alu_op}, 64'h2);
    wait_rsp(n);
    chk("t1_latency", 64'(n), 64'd4);
    chk("t1_rsp_s", rsp_s, 64'h0);
    chk("t1_rsp_cout", {63'b0, rsp_cout}, 64'h1);
    chk("t1_rsp_id", {62'b0, rsp_id}, 64'h0);
    tick();

    // 2: all four requesting; reset first so the pointer starts at 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      set_req(i, 64'h100 * (i + 1), 64'h5, i[0], 2'b00);
    req_valid = 4'hF;
    #1;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (req_ready == 4'b0 && n < 20) begin
        tick();
        n++;
      end
      chk("t2_grant", {60'b0, req_ready}, 64'(1) << (g % 4));
      tg = cyc;
      if (g > 0) chk("t2_gap", 64'(tg - tprev), 64'd6);
      tprev = tg;
      tick();
      if (g == 4) req_valid = 4'b0;
      wait_rsp(n);
      chk("t2_rsp_id", {62'b0, rsp_id}, 64'(g % 4));
      chk("t2_rsp_s", rsp_s, exp_s[g % 4]);
    end
    tick();

    // 3: backpressure on req1's result while req0 waits.
    set_req(1, 64'hDEAD, 64'h1, 1'b0, 2'b01);
    set_req(0, 64'h7, 64'h8, 1'b0, 2'b00);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    chk("t3_grant", {60'b0, req_ready}, 64'h2);
    tick();
    req_valid = 4'b0001;
    wait_rsp(n);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t3_hold_valid", {63'b0, rsp_valid}, 64'h1);
      chk("t3_hold_s", rsp_s, 64'hDEAE);
      chk("t3_hold_id", {62'b0, rsp_id}, 64'h1);
      chk("t3_hold_ready", {60'b0, req_ready}, 64'h0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("t3_done_valid", {63'b0, rsp_valid}, 64'h0);
    chk("t3_next_grant", {60'b0, req_ready}, 64'h1);
    tick();
    req_valid = 4'b0;
    wait_rsp(n);
    chk("t3_req0_s", rsp_s, 64'hF);
    chk("t3_req0_id", {62'b0, rsp_id}, 64'h0);
    tick();

    // 4: req2 alone, carry out of the top bit plus cin.
    set_req(2, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 1'b1, 2'b11);
    req_valid = 4'b0100;
    #1;
    chk("t4_grant", {60'b0, req_ready}, 64'h4);
    tick();
    req_valid = 4'b0;
    wait_rsp(n);
    chk("t4_rsp_s", rsp_s, 64'h2);
    chk("t4_rsp_cout", {63'b0, rsp_cout}, 64'h1);
    chk("t4_rsp_id", {62'b0, rsp_id}, 64'h2);
    tick();

    // 6: pointer at 3 picks req3 over req0, then wraps to req0.
    set_req(0, 64'h1, 64'h1, 1'b0, 2'b00);
    set_req(3, 64'h10, 64'h20, 1'b0, 2'b00);
    req_valid = 4'b1001;
    #1;
    chk("t6_grant3", {60'b0, req_ready}, 64'h8);
    tick();
    wait_rsp(n);
    chk("t6_resp_ready", {60'b0, req_ready}, 64'h0);
    chk("t6_rsp_id3", {62'b0, rsp_id}, 64'h3);
    chk("t6_rsp_s3", rsp_s, 64'h30);
    tick();
    chk("t6_grant0", {60'b0, req_ready}, 64'h1);
    tick();
    req_valid = 4'b0;
    wait_rsp(n);
    chk("t6_rsp_id0", {62'b0, rsp_id}, 64'h0);
    chk("t6_rsp_s0", rsp_s, 64'h2);
    tick();

    // 5: reset two cycles into EXEC aborts the operation.
    set_req(1, 64'h5, 64'h6, 1'b1, 2'b01);
    req_valid = 4'b0010;
    #1;
    chk("t5_grant", {60'b0, req_ready}, 64'h2);
    tick();
    req_valid = 4'b0;
    tick(); tick();
    rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("t5_rst_alu_a", alu_a, 64'h0);
    chk("t5_rst_alu_b", alu_b, 64'h0);
    chk("t5_rst_alu_cin", {63'b0, alu_cin}, 64'h0);
    chk("t5_rst_alu_op", {62'b0, alu_op}, 64'h0);
    chk("t5_rst_rsp_valid", {63'b0, rsp_valid}, 64'h0);
    chk("t5_rst_rsp_s", rsp_s, 64'h0);
    chk("t5_rst_rsp_cout", {63'b0, rsp_cout}, 64'h0);
    chk("t5_rst_req_ready", {60'b0, req_ready}, 64'h0);
    tick(); tick();
    req_valid = 4'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      seen = seen | rsp_valid;
    end
    chk("t5_no_rsp", {63'b0, seen}, 64'h0);
    set_req(1, 64'h20, 64'h3, 1'b1, 2'b00);
    set_req(2, 64'h40, 64'h4, 1'b0, 2'b00);
    req_valid = 4'b0110;
    #1;
    chk("t5_regrant", {60'b0, req_ready}, 64'h2);
    tick();
    req_valid = 4'b0;
    wait_rsp(n);
    chk("t5_rsp_id", {62'b0, rsp_id}, 64'h1);
    chk("t5_rsp_s", rsp_s, 64'h24);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
